// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator on the 5-bit CSR bus.
//   NUM_CH channels share one prescaler and one 8-bit period counter. Each
//   channel has its own duty, enable and polarity. PERIOD and DUTY are
//   double-buffered: the active copies are reloaded only at a counter wrap,
//   or on every clock while all channels are disabled.
// Ports:
//   clk, rst_n     system clock, async active-low reset
//   csr_a/di/we    CSR address, write data, one-cycle write strobe
//   csr_do         combinational read data, 0 outside this block (OR-bus)
//   pwm_out        registered PWM outputs, one per channel
//   pwm_en         channel enables (CTRL.EN), for pin muxing
//   irq            registered level interrupt, STATUS.WRAP & STATUS.IE

// Per-channel slice: duty shadow, active duty and the output flop.
module pwm_multi_ch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       duty_we_i,
  input  logic [7:0] wdata_i,
  input  logic       load_i,
  input  logic [7:0] cnt_i,
  input  logic       en_i,
  input  logic       pol_i,
  output logic [7:0] duty_o,
  output logic       pwm_o
);
  logic [7:0] duty_q, duty_act_q;
  logic       pwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q     <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      if (duty_we_i) duty_q <= wdata_i;
      // load sees the shadow from before this edge's write, so a write
      // in the wrap cycle lands one period later.
      if (load_i) duty_act_q <= duty_q;
      pwm_q <= en_i ? ((cnt_i < duty_act_q) ^ pol_i) : pol_i;
    end
  end

  assign duty_o = duty_q;
  assign pwm_o  = pwm_q;
endmodule

module pwm_multi #(
  parameter logic [4:0] BASE_ADDR = 5'h0c,
  parameter int         NUM_CH    = 2,
  parameter logic [7:0] PRESCALE  = 8'h90
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        csr_a,
  input  logic [7:0]        csr_di,
  input  logic              csr_we,
  output logic [7:0]        csr_do,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] pwm_en,
  output logic              irq
);
  localparam int LAST = 2 + NUM_CH;

  logic [NUM_CH-1:0]      en_q, pol_q;
  logic [7:0]             period_q, period_act_q;
  logic                   wrap_q, wrap_d, ie_q, irq_q;
  logic [7:0]             presc_q, presc_d, cnt_q, cnt_d;
  logic [NUM_CH-1:0][7:0] duty_sh;
  logic [NUM_CH-1:0]      duty_we;

  // Address decode: offset computed one bit wider so addresses below
  // BASE_ADDR wrap far above LAST and never alias.
  logic [5:0] off;
  logic       hit, wr_en, wr_ctrl, wr_period, wr_status;
  assign off       = {1'b0, csr_a} - {1'b0, BASE_ADDR};
  assign hit       = (csr_a >= BASE_ADDR) && (off <= 6'(LAST));
  assign wr_en     = csr_we && hit;
  assign wr_ctrl   = wr_en && (off == 6'd0);
  assign wr_period = wr_en && (off == 6'd1);
  assign wr_status = wr_en && (off == 6'd2);

  logic running, tick, wrap, load;
  assign running = |en_q;
  assign tick    = running && (presc_q == PRESCALE);
  assign wrap    = tick && (cnt_q == period_act_q);
  // Idle: active copies track the shadows so the first enable starts clean.
  assign load    = !running || wrap;

  always_comb begin
    presc_d = '0;
    cnt_d   = '0;
    if (running) begin
      presc_d = tick ? 8'd0 : presc_q + 8'd1;
      cnt_d   = cnt_q;
      if (tick) cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
    end
    // Set wins over a same-cycle write-1-to-clear.
    wrap_d = wrap | (wrap_q & ~(wr_status & csr_di[0]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q         <= '0;
      pol_q        <= '0;
      period_q     <= 8'hff;
      period_act_q <= '0;
      wrap_q       <= 1'b0;
      ie_q         <= 1'b0;
      irq_q        <= 1'b0;
      presc_q      <= '0;
      cnt_q        <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      irq_q   <= wrap_q & ie_q;
      if (load)      period_act_q <= period_q;
      if (wr_period) period_q     <= csr_di;
      if (wr_status) ie_q         <= csr_di[1];
      if (wr_ctrl) begin
        en_q  <= csr_di[NUM_CH-1:0];
        pol_q <= csr_di[4 +: NUM_CH];
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign duty_we[i] = wr_en && (off == 6'(3 + i));
    pwm_multi_ch u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .duty_we_i (duty_we[i]),
      .wdata_i   (csr_di),
      .load_i    (load),
      .cnt_i     (cnt_q),
      .en_i      (en_q[i]),
      .pol_i     (pol_q[i]),
      .duty_o    (duty_sh[i]),
      .pwm_o     (pwm_out[i])
    );
  end

  // Reads always return shadow values, never the active copies.
  always_comb begin
    csr_do = '0;
    if (hit) begin
      case (off)
        6'd0:    csr_do = {4'(pol_q), 4'(en_q)};
        6'd1:    csr_do = period_q;
        6'd2:    csr_do = {6'b0, ie_q, wrap_q};
        default: begin
          for (int i = 0; i < NUM_CH; i++)
            if (off == 6'(3 + i)) csr_do = duty_sh[i];
        end
      endcase
    end
  end

  assign pwm_en = en_q;
  assign irq    = irq_q;
endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;
  localparam int NCH   = 2;
  localparam int BASE  = 12;
  localparam int PRESC = 0;
  localparam int A_CTRL = BASE, A_PER = BASE + 1, A_STAT = BASE + 2;
  localparam int A_D0 = BASE + 3, A_D1 = BASE + 4;

  logic           clk, rst_n;
  logic [4:0]     csr_a;
  logic [7:0]     csr_di, csr_do;
  logic           csr_we, irq;
  logic [NCH-1:0] pwm_out, pwm_en;

  int checks = 0;
  int fails  = 0;

  pwm_multi #(.BASE_ADDR(5'h0c), .NUM_CH(NCH), .PRESCALE(8'(PRESC))) dut (
    .clk(clk), .rst_n(rst_n), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do), .pwm_out(pwm_out), .pwm_en(pwm_en), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, required finish before 500000");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [NCH-1:0] m_en, m_pol, m_out;
  bit             m_wrap, m_ie, m_irq;
  int             m_per, m_presc, m_cnt, m_pact;
  int             m_duty[NCH], m_dact[NCH];

  task automatic model_reset();
    m_en = '0; m_pol = '0; m_out = '0;
    m_wrap = 0; m_ie = 0; m_irq = 0;
    m_per = 255; m_presc = 0; m_cnt = 0; m_pact = 0;
    for (int i = 0; i < NCH; i++) begin m_duty[i] = 0; m_dact[i] = 0; end
  endtask

  // One clock edge of the register-level behaviour; everything on the right
  // hand side is the state from before the edge.
  task automatic model_step(input bit we, input int a, input int d);
    logic [NCH-1:0] nout;
    bit run, tk, wrp, nirq;
    int off;
    run = (m_en != 0);
    tk  = run && (m_presc == PRESC);
    wrp = tk && (m_cnt == m_pact);
    for (int i = 0; i < NCH; i++)
      nout[i] = m_en[i] ? ((m_cnt < m_dact[i]) ^ m_pol[i]) : m_pol[i];
    nirq = m_wrap && m_ie;
    if (!run) begin
      m_presc = 0; m_cnt = 0;
    end else begin
      m_presc = tk ? 0 : m_presc + 1;
      if (tk) m_cnt = wrp ? 0 : m_cnt + 1;
    end
    if (!run || wrp) begin
      m_pact = m_per;
      for (int i = 0; i < NCH; i++) m_dact[i] = m_duty[i];
    end
    off = a - BASE;
    if (we && off >= 0 && off <= 2 + NCH) begin
      case (off)
        0: begin m_en = NCH'(d); m_pol = NCH'(d >> 4); end
        1: m_per = d & 255;
        2: begin m_ie = d[1]; if (d[0]) m_wrap = 0; end
        default: m_duty[off-3] = d & 255;
      endcase
    end
    if (wrp) m_wrap = 1;
    m_out = nout;
    m_irq = nirq;
  endtask

  function automatic logic [7:0] m_read(input int a);
    int off;
    off = a - BASE;
    if (off < 0 || off > 2 + NCH) return 8'h00;
    case (off)
      0: return {4'(m_pol), 4'(m_en)};
      1: return 8'(m_per);
      2: return {6'b0, m_ie, m_wrap};
      default: return 8'(m_duty[off-3]);
    endcase
  endfunction

  // Drive one cycle, step the model at the edge, return 2 time units later.
  task automatic cyc(input bit we, input int a, input int d);
    csr_we = we; csr_a = 5'(a); csr_di = 8'(d);
    @(posedge clk);
    model_step(we, a, d);
    #2;
    csr_we = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    cyc(1'b1, a, d);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] exp_rst[5];
    exp_rst[0] = 8'h00; exp_rst[1] = 8'hff; exp_rst[2] = 8'h00;
    exp_rst[3] = 8'h00; exp_rst[4] = 8'h00;
    rst_n = 1'b0; csr_we = 1'b1; csr_a = 5'(A_CTRL); csr_di = 8'hff;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (pwm_out !== '0) begin fails++; $display("FAIL reset_pwm_out: got %b want 0", pwm_out); end
    checks++;
    if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", irq); end
    csr_we = 1'b0;
    rst_n  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      csr_a = 5'(BASE + k); #1;
      checks++;
      if (csr_do !== exp_rst[k])
        begin fails++; $display("FAIL reset_read[%0d]: got %h want %h", k, csr_do, exp_rst[k]); end
    end
  endtask

  task automatic test_basic();
    bit exp;
    wr(A_PER, 9); wr(A_D0, 3); wr(A_CTRL, 8'h01);
    for (int k = 1; k <= 21; k++) begin
      cyc(0, 0, 0);
      exp = ((k - 1) % 10) < 3;
      checks++;
      if (pwm_out[0] !== exp)
        begin fails++; $display("FAIL basic_pattern k=%0d: got %b want %b", k, pwm_out[0], exp); end
      checks++;
      if (pwm_out !== m_out)
        begin fails++; $display("FAIL basic_model k=%0d: got %b want %b", k, pwm_out, m_out); end
    end
    wr(A_CTRL, 8'h00);
    checks++;
    if (pwm_out[0] !== 1'b1) begin fails++; $display("FAIL basic_dis_edge: got %b want 1", pwm_out[0]); end
    cyc(0, 0, 0);
    checks++;
    if (pwm_out[0] !== 1'b0) begin fails++; $display("FAIL basic_dis_next: got %b want 0", pwm_out[0]); end
  endtask

  task automatic test_double_buffer();
    int n, highs;
    wr(A_D0, 3); wr(A_CTRL, 8'h01);
    n = 0;
    while (m_cnt != 5 && n < 40) begin cyc(0, 0, 0); n++; end
    checks++;
    if (n >= 40) begin fails++; $display("FAIL dbuf_wait: cycles %0d want <40", n); end
    wr(A_D0, 8);
    csr_a = 5'(A_D0); #1;
    checks++;
    if (csr_do !== 8'd8) begin fails++; $display("FAIL dbuf_read: got %h want 08", csr_do); end
    highs = 0;
    for (int k = 0; k < 14; k++) begin
      cyc(0, 0, 0);
      highs += int'(pwm_out[0]);
      checks++;
      if (pwm_out !== m_out)
        begin fails++; $display("FAIL dbuf_model k=%0d: got %b want %b", k, pwm_out, m_out); end
    end
    checks++;
    if (highs != 8) begin fails++; $display("FAIL dbuf_highs: got %0d want 8", highs); end
  endtask

  task automatic test_extremes();
    int lows;
    wr(A_D0, 0);
    repeat (12) cyc(0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0);
      checks++;
      if (pwm_out[0] !== 1'b0) begin fails++; $display("FAIL duty0_low k=%0d: got %b want 0", k, pwm_out[0]); end
    end
    wr(A_D0, 8'hff);
    repeat (12) cyc(0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0);
      checks++;
      if (pwm_out[0] !== 1'b1) begin fails++; $display("FAIL dutyff_high k=%0d: got %b want 1", k, pwm_out[0]); end
    end
    wr(A_D0, 3); wr(A_CTRL, 8'h11);
    repeat (12) cyc(0, 0, 0);
    lows = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0);
      lows += int'(!pwm_out[0]);
      checks++;
      if (pwm_out !== m_out)
        begin fails++; $display("FAIL pol_model k=%0d: got %b want %b", k, pwm_out, m_out); end
    end
    checks++;
    if (lows != 3) begin fails++; $display("FAIL pol_lows: got %0d want 3", lows); end
    wr(A_CTRL, 8'h10);
    repeat (2) cyc(0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0);
      checks++;
      if (pwm_out[0] !== 1'b1) begin fails++; $display("FAIL pol_idle_high k=%0d: got %b want 1", k, pwm_out[0]); end
    end
    // PERIOD = 0: one-tick period, constant active with DUTY >= 1.
    wr(A_CTRL, 8'h00); wr(A_PER, 0); wr(A_D0, 1); wr(A_CTRL, 8'h01);
    repeat (2) cyc(0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0);
      checks++;
      if (pwm_out[0] !== 1'b1) begin fails++; $display("FAIL per0_high k=%0d: got %b want 1", k, pwm_out[0]); end
    end
    wr(A_CTRL, 8'h00); wr(A_PER, 9);
  endtask

  task automatic test_irq();
    int n;
    wr(A_PER, 4); wr(A_D0, 2); wr(A_STAT, 8'h02); wr(A_CTRL, 8'h01);
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0);
      checks++;
      if (irq !== m_irq || pwm_out !== m_out)
        begin fails++; $display("FAIL irq_run k=%0d: got irq=%b out=%b want irq=%b out=%b", k, irq, pwm_out, m_irq, m_out); end
    end
    // W1C in the same cycle as a wrap: set wins.
    n = 0;
    while (!(m_en != 0 && m_presc == PRESC && m_cnt == m_pact) && n < 20) begin cyc(0, 0, 0); n++; end
    checks++;
    if (n >= 20) begin fails++; $display("FAIL irq_wait_wrap: cycles %0d want <20", n); end
    wr(A_STAT, 8'h03);
    csr_a = 5'(A_STAT); #1;
    checks++;
    if (csr_do !== 8'h03) begin fails++; $display("FAIL w1c_conflict: got %h want 03", csr_do); end
    cyc(0, 0, 0);
    checks++;
    if (irq !== 1'b1) begin fails++; $display("FAIL w1c_conflict_irq: got %b want 1", irq); end
    // W1C away from a wrap drops irq one clock later.
    n = 0;
    while (m_cnt != 1 && n < 20) begin cyc(0, 0, 0); n++; end
    checks++;
    if (n >= 20) begin fails++; $display("FAIL irq_wait_cnt: cycles %0d want <20", n); end
    wr(A_STAT, 8'h03);
    checks++;
    if (irq !== 1'b1) begin fails++; $display("FAIL w1c_edge_irq: got %b want 1", irq); end
    cyc(0, 0, 0);
    checks++;
    if (irq !== 1'b0) begin fails++; $display("FAIL w1c_irq_drop: got %b want 0", irq); end
    csr_a = 5'(A_STAT); #1;
    checks++;
    if (csr_do !== 8'h02) begin fails++; $display("FAIL w1c_status: got %h want 02", csr_do); end
    // IE = 0 masks the interrupt while WRAP keeps getting set.
    repeat (6) cyc(0, 0, 0);
    wr(A_STAT, 8'h00);
    repeat (2) cyc(0, 0, 0);
    checks++;
    if (irq !== 1'b0) begin fails++; $display("FAIL ie0_irq: got %b want 0", irq); end
    csr_a = 5'(A_STAT); #1;
    checks++;
    if (csr_do !== 8'h01) begin fails++; $display("FAIL ie0_status: got %h want 01", csr_do); end
  endtask

  task automatic test_bus();
    wr(A_CTRL, 8'hff);
    csr_a = 5'h0c; #1;
    checks++;
    if (csr_do !== 8'h33) begin fails++; $display("FAIL ctrl_mask: got %h want 33", csr_do); end
    csr_a = 5'h0b; #1;
    checks++;
    if (csr_do !== 8'h00) begin fails++; $display("FAIL decode_0b: got %h want 00", csr_do); end
    csr_a = 5'h11; #1;
    checks++;
    if (csr_do !== 8'h00) begin fails++; $display("FAIL decode_11: got %h want 00", csr_do); end
    wr(5'h0b, 8'h5a); wr(5'h11, 8'h5a); wr(5'h1f, 8'h5a); wr(5'h00, 8'h5a); wr(5'h0a, 8'h5a);
    csr_a = 5'h0c; #1;
    checks++;
    if (csr_do !== 8'h33) begin fails++; $display("FAIL stray_ctrl: got %h want 33", csr_do); end
    csr_a = 5'h0d; #1;
    checks++;
    if (csr_do !== 8'h04) begin fails++; $display("FAIL stray_period: got %h want 04", csr_do); end
    csr_a = 5'h0f; #1;
    checks++;
    if (csr_do !== 8'h02) begin fails++; $display("FAIL stray_duty0: got %h want 02", csr_do); end
    csr_a = 5'h10; #1;
    checks++;
    if (csr_do !== 8'h00) begin fails++; $display("FAIL stray_duty1: got %h want 00", csr_do); end
  endtask

  task automatic test_random();
    int a, d, ra;
    wr(A_CTRL, 8'h00);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 3) begin
        a = BASE + $urandom_range(0, 2 + NCH);
        if (a == A_PER) d = $urandom_range(0, 12);
        else if (a >= A_D0) d = $urandom_range(0, 14);
        else d = $urandom_range(0, 255);
        wr(a, d);
      end else begin
        cyc(0, 0, 0);
      end
      checks++;
      if (pwm_out !== m_out || pwm_en !== m_en || irq !== m_irq)
        begin fails++; $display("FAIL rand_out k=%0d: got out=%b en=%b irq=%b want out=%b en=%b irq=%b",
                                k, pwm_out, pwm_en, irq, m_out, m_en, m_irq); end
      ra = $urandom_range(BASE - 2, BASE + 2 + NCH + 2);
      csr_a = 5'(ra); #1;
      checks++;
      if (csr_do !== m_read(ra))
        begin fails++; $display("FAIL rand_read k=%0d a=%h: got %h want %h", k, ra, csr_do, m_read(ra)); end
    end
  endtask

  task automatic test_reset_mid();
    wr(A_CTRL, 8'h00); wr(A_PER, 9); wr(A_D0, 5); wr(A_D1, 5);
    wr(A_STAT, 8'h02); wr(A_CTRL, 8'h23);
    repeat (13) cyc(0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== '0) begin fails++; $display("FAIL midreset_out: got %b want 0", pwm_out); end
    checks++;
    if (irq !== 1'b0) begin fails++; $display("FAIL midreset_irq: got %b want 0", irq); end
    csr_a = 5'(A_PER); #1;
    checks++;
    if (csr_do !== 8'hff) begin fails++; $display("FAIL midreset_period: got %h want ff", csr_do); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    model_reset();
    cyc(0, 0, 0);
    checks++;
    if (pwm_out !== m_out) begin fails++; $display("FAIL midreset_release: got %b want %b", pwm_out, m_out); end
    wr(A_CTRL, 8'h20);
    cyc(0, 0, 0);
    checks++;
    if (pwm_out !== 2'b10) begin fails++; $display("FAIL midreset_pol: got %b want 10", pwm_out); end
  endtask

  initial begin
    csr_a = '0; csr_di = '0; csr_we = 1'b0; rst_n = 1'b0;
    test_reset();
    test_basic();
    test_double_buffer();
    test_extremes();
    test_irq();
    test_bus();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator on the 5-bit CSR bus, the successor to the single-channel `pwm` block. NUM_CH channels share one prescaler and one period counter. Each channel has its own duty, enable and polarity. Period and duty writes are double-buffered and only take effect at a period boundary, so outputs never glitch. A wrap flag with an interrupt enable is added, and its `irq` line is ORed into the CPLD interrupt.

## Interface
- `BASE_ADDR`, 5'h0c: first CSR address. The block occupies `BASE_ADDR` .. `BASE_ADDR+2+NUM_CH`.
- `NUM_CH`, 2: channel count, 1..4.
- `PRESCALE`, 8'h90: one tick every PRESCALE+1 clocks.
- `clk` in 1: system clock, the UFM oscillator.
- `rst_n` in 1: asynchronous, active-low reset.
- `csr_a` in 5: CSR address.
- `csr_di` in 8: CSR write data.
- `csr_we` in 1: CSR write strobe, one cycle per write.
- `csr_do` out 8: read data. Combinational from `csr_a`; 0 when the address is outside this block (OR-bus).
- `pwm_out` out NUM_CH: registered PWM outputs.
- `pwm_en` out NUM_CH: channel enables, used for pin muxing in top.
- `irq` out 1: registered level interrupt, STATUS.WRAP & STATUS.IE.

## Operation
Register map:
- **CTRL** (+0)
  - [3:0] EN: channel enable. Bits ≥ NUM_CH are not stored and read 0.
  - [7:4] POL: channel polarity; same rule for bits ≥ NUM_CH.
  - Reset 0.
- **PERIOD** (+1): counter top value. Reset 8'hff.
- **STATUS** (+2)
  - [0] WRAP: set at each counter wrap; write 1 to clear.
  - [1] IE: read/write interrupt enable.
  - [7:2] read 0.
  - Reset 0.
- **DUTY_i** (+3+i): active ticks per period for channel i. Reset 0.

Behaviour:
- Reads return the programmed (shadow) values, never the active copies.
- **Prescaler:** `presc` counts 0..PRESCALE and emits a one-clock `tick` when `presc == PRESCALE`, then reloads 0.
- **Counter:** 8-bit `cnt` advances on `tick`. When `cnt == period_act`, the tick sets `cnt` to 0 (wrap), copies PERIOD and all DUTY into the active registers, and sets WRAP.
- **Idle state:** while CTRL.EN == 0, `presc` and `cnt` are held at 0, and the active registers follow the shadows every clock. The first enable therefore starts a clean period with the current settings.
- **Output:** `pwm_out[i] <= EN[i] ? ((cnt < duty_act[i]) ^ POL[i]) : POL[i]`.
  - DUTY = 0 gives constant inactive.
  - DUTY > period_act gives constant active.
  - Period length is period_act+1 ticks.
  - PERIOD = 0 gives a 1-tick period: output constant active if DUTY ≥ 1.
- **Enable changes:** enabling or disabling one channel while others run does not disturb `cnt`.
- `pwm_en = CTRL.EN[NUM_CH-1:0]`.
- **WRAP conflict:** a write-1-to-clear of WRAP in the same cycle as a wrap leaves WRAP = 1 (set wins).

## Timing
- **Reset (asynchronous)** clears:
  - CTRL, STATUS and DUTY;
  - PERIOD = 8'hff;
  - all active copies;
  - `presc`, `cnt`, `pwm_out` = 0, `irq` = 0.
- **CSR writes** land on the `clk` edge where `csr_we` = 1; reads reflect the new value the next cycle.
- **`pwm_out` latency:** updates one clock after the edge that changes `cnt`, CTRL.EN or CTRL.POL.
  - POL/EN changes are effective immediately, without waiting for the boundary.
  - PERIOD/DUTY changes apply only at the next wrap (or immediately when idle).
- **Tick spacing:** exactly PRESCALE+1 clocks apart while enabled. The first tick after enabling comes PRESCALE+1 clocks after the EN write edge.
- **`irq`:** asserts one clock after WRAP is set (with IE = 1), and deasserts one clock after the W1C or IE = 0 write.
- **`rst_n` mid-period:** outputs go to 0 immediately (asynchronous), including channels with POL = 1. They return to the POL level one clock after release.

## Test plan
- **Reset values:** assert `rst_n`=0 during activity → `pwm_out`=0, `irq`=0; after release, reads give CTRL=0, PERIOD=ff, STATUS=0, DUTY=0.
- **Basic duty:** PRESCALE=0, PERIOD=9, DUTY0=3, EN0=1 → `pwm_out[0]` high 3 clocks, low 7, repeating. Clear EN0 → low on the next clock.
- **Double-buffered update:** running at DUTY0=3; write DUTY0=8 at `cnt`=5 → the rest of that period still uses 3; the next period is high 8 of 10. Read DUTY0 returns 8 immediately.
- **Extremes and polarity:** DUTY=0 → constant low; DUTY=ff with PERIOD=9 → constant high; POL0=1 with DUTY=3 → low 3 / high 7, and POL0=1 with EN0=0 → constant high.
- **Interrupt:** IE=1, PERIOD=4, PRESCALE=0 → WRAP/`irq` set every 5 clocks. A W1C in the same cycle as a wrap keeps WRAP=1; a W1C otherwise drops `irq` next clock.
- **Bus decode:** with BASE_ADDR=0c, NUM_CH=2 → `csr_do`=0 for addresses 0b and 11. Writing CTRL=ff reads back 33. Writes to other addresses leave all registers unchanged.
